// File: rtl/nn_sample_sequencer.sv
// nn_sample_sequencer: queues operand pairs and runs one nn inference
// per pair (reset, gap, enable pulse, wait for done), then offers the
// captured result downstream on a valid/ready port.
// Ports:
//   clk, reset          clock and async active-high reset
//   in_valid/in_ready   operand pair input handshake
//   in_data_1/2         operands (signed)
//   nn_resetn           active-low reset to nn core
//   nn_enable           one-cycle start pulse to nn
//   nn_input_1/2        operands latched for the current sample
//   nn_done             nn finished (sampled only while waiting)
//   nn_final_output     nn result
//   nn_total_ovf/zero   nn flags
//   out_valid/out_ready result output handshake
//   out_data            result, all-ones when overflowed
//   out_ovf/zero        captured flags
//   out_timeout         nn never signalled done for this sample
//   seq_state           FSM state for debug
//   sample_count        results accepted downstream (wraps)
module nn_sample_sequencer #(
  parameter int SIZE           = 32,
  parameter int DEPTH          = 4,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data_1,
  input  logic [SIZE-1:0] in_data_2,
  output logic            nn_resetn,
  output logic            nn_enable,
  output logic [SIZE-1:0] nn_input_1,
  output logic [SIZE-1:0] nn_input_2,
  input  logic            nn_done,
  input  logic [SIZE-1:0] nn_final_output,
  input  logic            nn_total_ovf,
  input  logic            nn_total_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_ovf,
  output logic            out_zero,
  output logic            out_timeout,
  output logic [2:0]      seq_state,
  output logic [15:0]     sample_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CMAX = (TIMEOUT_CYCLES > RST_CYCLES) ?
                        TIMEOUT_CYCLES : RST_CYCLES;
  localparam int NW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NN_RST = 3'd1,
    S_NN_GAP = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_OUTPUT = 3'd5
  } state_e;

  // FIFO storage and pointers
  logic [2*SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full, empty, push, pop;
  logic [2*SIZE-1:0] head;

  // sequencer state
  state_e            state_q, state_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [SIZE-1:0]   in1_q, in1_d;
  logic [SIZE-1:0]   in2_q, in2_d;
  logic              rstn_q, rstn_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              to_q, to_d;
  logic [15:0]       scnt_q, scnt_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data_2, in_data_1};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    to_d    = to_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          in1_d   = head[SIZE-1:0];
          in2_d   = head[2*SIZE-1:SIZE];
          cnt_d   = '0;
          state_d = S_NN_RST;
        end
      end
      S_NN_RST: begin
        if (cnt_q == NW'(RST_CYCLES - 1)) begin
          state_d = S_NN_GAP;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      S_NN_GAP: state_d = S_LAUNCH;
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (nn_done) begin
          ovf_d   = nn_total_ovf;
          zero_d  = nn_total_zero;
          to_d    = 1'b0;
          data_d  = nn_total_ovf ? {SIZE{1'b1}} : nn_final_output;
          state_d = S_OUTPUT;
        end else if (cnt_q == NW'(TIMEOUT_CYCLES - 1)) begin
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          to_d    = 1'b1;
          data_d  = '0;
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          scnt_d  = scnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // strobes are registered from the next state
    rstn_d = (state_d != S_NN_RST);
    en_d   = (state_d == S_LAUNCH);
    vld_d  = (state_d == S_OUTPUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      rstn_q   <= 1'b1;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      to_q     <= 1'b0;
      scnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      rstn_q   <= rstn_d;
      en_q     <= en_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      to_q     <= to_d;
      scnt_q   <= scnt_d;
    end
  end

  // nn is held in reset for as long as we are
  assign nn_resetn    = rstn_q && !reset;
  assign nn_enable    = en_q;
  assign nn_input_1   = in1_q;
  assign nn_input_2   = in2_q;
  assign in_ready     = !full;
  assign out_valid    = vld_q;
  assign out_data     = data_q;
  assign out_ovf      = ovf_q;
  assign out_zero     = zero_q;
  assign out_timeout  = to_q;
  assign seq_state    = state_q;
  assign sample_count = scnt_q;

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Bench for nn_sample_sequencer: a stub nn core plus a queue-based
// reference of expected results, driven by directed and random steps.
module tb_nn_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data_1;
  logic [31:0] in_data_2;
  logic        nn_resetn;
  logic        nn_enable;
  logic [31:0] nn_input_1;
  logic [31:0] nn_input_2;
  logic        nn_done = 1'b0;
  logic [31:0] nn_final_output = '0;
  logic        nn_total_ovf = 1'b0;
  logic        nn_total_zero = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_zero;
  logic        out_timeout;
  logic [2:0]  seq_state;
  logic [15:0] sample_count;

  always #5 clk = ~clk;

  nn_sample_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .nn_resetn(nn_resetn), .nn_enable(nn_enable),
    .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
    .nn_done(nn_done), .nn_final_output(nn_final_output),
    .nn_total_ovf(nn_total_ovf), .nn_total_zero(nn_total_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_timeout(out_timeout),
    .seq_state(seq_state), .sample_count(sample_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cyc = 0;
  int valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // stub nn: result = in1+in2, ovf = in1[0], zero = in2[0];
  // done pulses stub_delay cycles after the enable cycle
  int stub_delay = 1;
  bit stub_hang = 0;
  int s_cnt = 0;
  bit s_armed = 0;

  always @(negedge clk) begin
    if (!nn_resetn) begin
      s_armed = 0;
      nn_done = 1'b0;
    end else begin
      nn_done = 1'b0;
      if (nn_enable) begin
        s_armed = 1;
        s_cnt = stub_delay;
        nn_final_output = nn_input_1 + nn_input_2;
        nn_total_ovf = nn_input_1[0];
        nn_total_zero = nn_input_2[0];
      end else if (s_armed && !stub_hang) begin
        s_cnt = s_cnt - 1;
        if (s_cnt == 0) begin
          nn_done = 1'b1;
          s_armed = 0;
        end
      end
    end
  end

  // lengths of the most recent completed enable / reset pulses
  int en_run = 0, en_len = 0, rst_run = 0, rst_len = 0;
  always @(negedge clk) begin
    if (nn_enable) en_run++;
    else if (en_run > 0) begin en_len = en_run; en_run = 0; end
    if (!nn_resetn) rst_run++;
    else if (rst_run > 0) begin rst_len = rst_run; rst_run = 0; end
  end

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] data;
    logic        ovf;
    logic        zero;
    logic        to;
  } exp_t;

  exp_t q[$];
  logic [15:0] exp_count = '0;

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, bit hang);
    exp_t e;
    e.d1 = a;
    e.d2 = b;
    if (hang) begin
      e.data = '0; e.ovf = 0; e.zero = 0; e.to = 1;
    end else begin
      e.ovf = a[0];
      e.zero = b[0];
      e.to = 0;
      e.data = e.ovf ? 32'hFFFF_FFFF : a + b;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [31:0] a, logic [31:0] b);
    int n = 0;
    in_data_1 = a;
    in_data_2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("push_wait", in_ready, 1);
    @(posedge clk);
    q.push_back(mk(a, b, stub_hang));
    @(negedge clk);
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!out_valid && n < budget) begin @(negedge clk); n++; end
    valid_cyc = cyc;
    chk("valid_wait", out_valid, 1);
  endtask

  task automatic get_result(string tag, int budget);
    exp_t e;
    wait_valid(budget);
    out_ready = 1'b1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=unexpected_result expected=none", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, out_data, e.data);
      chk({tag, "_ovf"}, out_ovf, e.ovf);
      chk({tag, "_zero"}, out_zero, e.zero);
      chk({tag, "_to"}, out_timeout, e.to);
      chk({tag, "_in1"}, nn_input_1, e.d1);
      chk({tag, "_in2"}, nn_input_2, e.d2);
    end
    @(posedge clk);
    exp_count++;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_cnt"}, sample_count, exp_count);
    chk({tag, "_vdrop"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    int k, d, n;
    exp_t e;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nn_resetn", nn_resetn, 0);
    chk("rst_nn_enable", nn_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_state", seq_state, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_in1", nn_input_1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_nn_resetn", nn_resetn, 1);

    // single sample, done 5 cycles after enable
    stub_delay = 5;
    stub_hang = 0;
    push(32'h60, 32'h4);
    k = push_cyc;
    wait_valid(50);
    chk("single_latency", valid_cyc - k, 10);
    chk("single_en_len", en_len, 1);
    chk("single_rst_len", rst_len, 2);
    get_result("single", 1);

    // overflow and zero flag samples
    push(32'h1234_5671, 32'h7);
    get_result("ovf", 50);
    push(32'h2, 32'h1);
    get_result("zero", 50);

    // downstream stall: one sample held, FIFO fills behind it
    stub_delay = 2;
    push($urandom, $urandom);
    wait_valid(50);
    for (int i = 0; i < 4; i++) begin
      push($urandom, $urandom);
      chk("fill_ready", in_ready, (i < 3) ? 1 : 0);
    end
    e = q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, e.data);
      chk("stall_in1", nn_input_1, e.d1);
    end
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_block", in_ready, 0);
    in_valid = 1'b0;
    get_result("stall0", 5);
    push($urandom, $urandom);
    for (int i = 0; i < 5; i++) get_result("drain", 60);

    // nn never finishes: timeout, then a normal sample
    stub_hang = 1;
    push(32'hAAAA_0000, 32'h5);
    k = push_cyc;
    wait_valid(200);
    chk("to_latency", valid_cyc - k, 69);
    get_result("timeout", 1);
    stub_hang = 0;
    stub_delay = 1;
    push(32'h10, 32'h20);
    get_result("after_to", 50);

    // random operands and completion delays
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(1, 6);
      stub_delay = d;
      a = $urandom;
      b = $urandom;
      push(a, b);
      k = push_cyc;
      wait_valid(60);
      chk("rand_latency", valid_cyc - k, d + 5);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_result("rand", 5);
    end

    // reset while waiting with two entries queued
    stub_delay = 40;
    push(32'h1, 32'h2);
    push(32'h3, 32'h4);
    push(32'h5, 32'h6);
    n = 0;
    while (seq_state != 3'd4 && n < 50) begin @(negedge clk); n++; end
    chk("mid_wait", seq_state, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_enable", nn_enable, 0);
    chk("mid_resetn", nn_resetn, 0);
    chk("mid_state", seq_state, 0);
    chk("mid_count", sample_count, 0);
    chk("mid_in1", nn_input_1, 0);
    chk("mid_data", out_data, 0);
    chk("mid_ready", in_ready, 1);
    q.delete();
    exp_count = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_state", seq_state, 0);
    chk("idle_valid", out_valid, 0);
    stub_delay = 1;
    push(32'h7, 32'h8);
    get_result("post_rst", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
